// File: rtl/dmem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_if : MEM-stage request/response bundle for the data memory.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dmem_if;
  logic        memenM;
  logic        memwriteM;
  logic [3:0]  selM;
  logic [31:0] addrM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        addr_errM;

  modport master (
    output memenM, memwriteM, selM, addrM, writedataM,
    input  readdataM, stallM, addr_errM
  );

  modport slave (
    input  memenM, memwriteM, selM, addrM, writedataM,
    output readdataM, stallM, addr_errM
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : multi-cycle data SRAM model with byte lanes, stall   |
// | generation and alignment checking.  Rev 1.0                          |
// +----------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                write_q, write_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  logic                misalign;
  logic                accept;
  logic                commit;
  logic                unused_addr_hi;

  // Upper address bits are deliberately ignored so accesses wrap.
  assign unused_addr_hi = ^bus.addrM[31:ADDR_W+2];

  always_comb begin
    misalign = 1'b0;
    if (bus.selM == 4'b1111 && bus.addrM[1:0] != 2'b00)
      misalign = 1'b1;
    if ((bus.selM == 4'b0011 || bus.selM == 4'b1100) && bus.addrM[0])
      misalign = 1'b1;
  end

  assign accept = (state_q == IDLE) && bus.memenM && !misalign;
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  assign bus.addr_errM = (state_q == IDLE) && bus.memenM && misalign;
  assign bus.stallM    = accept || (state_q == BUSY);
  assign bus.readdataM = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = bus.addrM[ADDR_W+1:2];
          write_d = bus.memwriteM;
          sel_d   = bus.selM;
          wdata_d = bus.writedataM;
          cnt_d   = LAT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (commit) begin
          if (!write_q)
            rdata_d = mem[idx_q];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Request inputs are not looked at here, so a held memenM cannot retrigger.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i])
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
